wb_evict_buffer: RTL
====================

# wb_evict_buffer

Write-back eviction buffer between the `set_associative_wb` cache and backing memory. It accepts dirty victim words evicted by the cache and queues them in a small FIFO, coalescing repeat evictions to the same address. It drains entries to memory through a req/ack handshake and answers cache miss-path lookups against queued data, so a refill never reads stale memory.

## Interface
- `ADDR_W`, 32, address width (byte address, full-width compare)
- `DATA_W`, 32, data word width
- `DEPTH`, 4, number of buffer entries; power of two, ≥2
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `evict_valid`  in  1  cache presents a dirty victim this cycle
- `evict_addr`  in  ADDR_W  victim address
- `evict_data`  in  DATA_W  victim data
- `evict_ready`  out  1  buffer can accept; equals `!full`
- `lookup_addr`  in  ADDR_W  cache miss address to check against the buffer
- `lookup_hit`  out  1  combinational; some valid entry matches `lookup_addr`
- `lookup_data`  out  DATA_W  data of the matching entry; 0 when no hit
- `mem_req`  out  1  registered; write request to memory
- `mem_addr`  out  ADDR_W  head entry address, valid while `mem_req`
- `mem_wdata`  out  DATA_W  head entry data, valid while `mem_req`
- `mem_ack`  in  1  memory accepted the write; sampled only while `mem_req`=1
- `count`  out  $clog2(DEPTH)+1  number of valid entries
- `full`  out  1  `count == DEPTH`
- `empty`  out  1  `count == 0`

## Operation
- Storage: circular FIFO; head pointer, tail pointer and count, each registered. Pointers wrap modulo DEPTH.
- Accept: `evict_valid && evict_ready`.
  - Coalesce: if the address matches a valid entry that is not locked, overwrite that entry's data. No pointer or count change.
  - Otherwise, write at tail, advance tail, and increment count.
- Lock: the head entry is locked while the FSM is in REQ. Its address and data must not change while it is presented to memory. A matching evict during REQ allocates a new entry.
- Lookup: compare `lookup_addr` against all valid entries, including the locked head. With multiple matches (possible only through the lock rule), the newest entry wins: the one closest to tail.
- Drain FSM, two states:
  - IDLE: if `!empty`, go to REQ and set `mem_req`=1.
  - REQ: hold `mem_req`=1 with head address and data. On `mem_ack`: pop head (advance head, decrement count), clear `mem_req`, return to IDLE.
  - `mem_ack` in IDLE is ignored.
- Simultaneous pop and accept in one cycle: count is unchanged, head and tail both advance.
- `evict_ready` follows `full` only. A pop in the same cycle does not make a full buffer ready; there is no pass-through.
- `mem_addr` and `mem_wdata` are driven from the head entry and are 0 when `empty`.

## Timing
- Reset values: `count`=0, `empty`=1, `full`=0, `evict_ready`=1, `mem_req`=0, `mem_addr`=0, `mem_wdata`=0, `lookup_hit`=0, `lookup_data`=0. FSM returns to IDLE, pointers to 0, and all valid bits are cleared.
- Reset asserted mid-REQ drops `mem_req` immediately (asynchronous) and discards all entries.
- Accept latency: an entry accepted at edge N is visible to lookup after edge N and raises `mem_req` after edge N+1 when the buffer was empty.
- Drain throughput: minimum 2 cycles per entry (REQ, then IDLE). With `mem_ack` held high, one entry retires every 2 cycles.
- Lookup is purely combinational on the current registered state. The same-cycle incoming evict is not forwarded.
- A coalesce at edge N onto the head while in IDLE is valid: the REQ starting after edge N presents the new data.

## Test plan
- Reset, then evict 0x0000_0000/0xDEAD_0000 with `mem_ack`=0 -> `count`=1; one cycle later `mem_req`=1, `mem_addr`=0x0000_0000, `mem_wdata`=0xDEAD_0000. Pulse `mem_ack` -> `count`=0 and `mem_req`=0 the next cycle.
- With `mem_ack`=0, evict 0x00, 0x10, 0x20, 0x30 -> `full`=1, `evict_ready`=0. A fifth evict 0x1000_0000 is not accepted; `count` stays 4.
- Coalesce: evict 0x10/0xDEAD_0010, then 0x10/0xBEEF_0010 while the entry is not at the head or the head is not in REQ -> `count`=1 and lookup 0x10 returns 0xBEEF_0010.
- Lock: while head 0x00 is in REQ, evict 0x00/0xBEEF_0000 -> `count`=2, `mem_wdata` stays 0xDEAD_0000, and lookup 0x00 returns 0xBEEF_0000. After ack, the second REQ carries 0xBEEF_0000.
- Simultaneous: at `count`=2 in REQ, assert `mem_ack` and evict 0x40 in the same cycle -> `count` stays 2. Drain order is preserved and tail wraps correctly across 6+ entries.
- Assert reset mid-REQ with `count`=3 -> `mem_req`=0 immediately, `count`=0, and lookup of any prior address gives `lookup_hit`=0.

Source files
------------

// File: rtl/wb_evict_buffer.sv
// Write-back eviction buffer: queues dirty victims, coalesces repeat addresses,
// drains through a req/ack handshake and serves miss-path lookups from queued data.
module wb_evict_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     evict_valid,
    input  logic [ADDR_W-1:0]        evict_addr,
    input  logic [DATA_W-1:0]        evict_data,
    output logic                     evict_ready,
    input  logic [ADDR_W-1:0]        lookup_addr,
    output logic                     lookup_hit,
    output logic [DATA_W-1:0]        lookup_data,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t              state_reg, state_next;
    logic [PW-1:0]       head_reg, tail_reg;
    logic [CW-1:0]       count_reg;
    logic [DEPTH-1:0]    valid_reg;
    logic [ADDR_W-1:0]   addr_mem [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];

    logic [DEPTH-1:0]    lk_match, co_match;
    logic                co_hit;
    logic [PW-1:0]       co_idx, scan_idx;
    logic                accept, alloc, pop;

    assign full        = (count_reg == CW'(DEPTH));
    assign empty       = (count_reg == '0);
    assign count       = count_reg;
    assign evict_ready = !full;
    assign mem_req     = (state_reg == REQ);
    assign mem_addr    = empty ? '0 : addr_mem[head_reg];
    assign mem_wdata   = empty ? '0 : data_mem[head_reg];

    assign accept = evict_valid && evict_ready;
    assign alloc  = accept && !co_hit;
    assign pop    = (state_reg == REQ) && mem_ack;

    // The head is frozen while presented to memory, so it is never a coalesce target in REQ.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign lk_match[gi] = valid_reg[gi] && (addr_mem[gi] == lookup_addr);
            assign co_match[gi] = valid_reg[gi] && (addr_mem[gi] == evict_addr)
                                  && !((state_reg == REQ) && (head_reg == PW'(gi)));
        end
    endgenerate

    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (co_match[i]) begin
                co_hit = 1'b1;
                co_idx = PW'(i);
            end
        end
    end

    // Scan oldest to newest so the entry closest to tail wins on duplicates.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        scan_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_reg + PW'(i);
            if (lk_match[scan_idx]) begin
                lookup_hit  = 1'b1;
                lookup_data = data_mem[scan_idx];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!empty) state_next = REQ;
            REQ:     if (mem_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            valid_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            if (pop) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + PW'(1);
            end
            if (alloc) begin
                addr_mem[tail_reg]  <= evict_addr;
                data_mem[tail_reg]  <= evict_data;
                valid_reg[tail_reg] <= 1'b1;
                tail_reg            <= tail_reg + PW'(1);
            end else if (accept) begin
                data_mem[co_idx] <= evict_data;
            end
            case ({alloc, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule
